// File: rtl/seg_pkg.sv
// Shared 7-segment definitions for the display driver and the scan-capture monitor.
// The segment table is active-low, ordered {g,f,e,d,c,b,a}, and indexed by nibble value.
package seg_pkg;

    typedef logic [6:0] seg_n_t;
    typedef logic [3:0] nib_t;

    localparam seg_n_t SEG_BLANK_N = 7'h7F;

    localparam seg_n_t SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic hit;    // pattern is one of the 16 glyphs
        logic blank;  // pattern is all segments off
        nib_t nib;    // decoded value, 0 unless hit
    } seg_dec_t;

    function automatic seg_dec_t seg_decode(input seg_n_t seg_n);
        seg_dec_t d;
        d.hit   = 1'b0;
        d.blank = (seg_n == SEG_BLANK_N);
        d.nib   = '0;
        for (int i = 0; i < 16; i++) begin
            if (seg_n == SEG_LUT[i]) begin
                d.hit = 1'b1;
                d.nib = nib_t'(i);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational classification of one settled bus sample: the segment glyph, and
// whether the anode word selects exactly one digit, no digit, or several.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [7:0] anode_n,
    input  seg_n_t     seg_n,
    output seg_dec_t   dec,
    output logic [2:0] idx,
    output logic       anode_ok,
    output logic       anode_idle
);

    assign dec        = seg_decode(seg_n);
    assign anode_idle = &anode_n;
    assign anode_ok   = ($countones(~anode_n) == 1);

    // idx is only meaningful when anode_ok; the loop keeps it latch-free otherwise.
    always_comb begin
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (!anode_n[i]) idx = 3'(i);
        end
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive side of the multiplexed 8-digit 7-segment bus: waits for each digit slot to
// settle, decodes it, keeps the recovered digits and streams every capture out.
module seg_scan_capture
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  anode_n,
    input  logic [6:0]  seg_n,
    output logic        cap_valid,
    input  logic        cap_ready,
    output logic [2:0]  cap_idx,
    output logic [3:0]  cap_nib,
    output logic        cap_blank,
    output logic [31:0] digits,
    output logic        frame_done,
    output logic        seg_err,
    output logic        anode_err,
    output logic        overflow,
    input  logic        err_clr
);

    localparam int            CW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    typedef struct packed {
        logic [7:0] anode_n;
        seg_n_t     seg_n;
    } bus_t;

    bus_t bus_in;
    bus_t sample;
    bus_t prev;

    assign bus_in = '{anode_n: anode_n, seg_n: seg_n};

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sample = bus_in;
        end else begin : g_sync
            bus_t sync_q [SYNC_STAGES];
            // NOTE: the synchroniser and compare register reset to the idle bus (all high),
            // so the first settle after reset is a harmless blanking interval, not an error.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
                end else begin
                    sync_q[0] <= bus_in;
                    for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign sample = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    logic          changed;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          evt_q;

    assign changed = (sample != prev);

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        cnt_next = cnt;
        if (changed)             cnt_next = '0;
        else if (cnt != CNT_MAX) cnt_next = cnt + CW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev  <= '1;
            cnt   <= '0;
            evt_q <= 1'b0;
        end else begin
            prev  <= sample;
            cnt   <= cnt_next;
            // One pulse on the transition into saturation, never while already saturated.
            evt_q <= (cnt_next == CNT_MAX) && (changed || (cnt != CNT_MAX));
        end
    end

    seg_dec_t   dec;
    logic [2:0] dec_idx;
    logic       anode_ok;
    logic       anode_idle;

    seg_pattern_decode u_decode (
        .anode_n   (prev.anode_n),
        .seg_n     (prev.seg_n),
        .dec       (dec),
        .idx       (dec_idx),
        .anode_ok  (anode_ok),
        .anode_idle(anode_idle)
    );

    logic       good;
    logic       cap_evt;
    logic       seg_evt;
    logic       anode_evt;
    logic       stalled;
    logic [7:0] mask;
    logic       mask_full;

    assign good      = dec.hit | dec.blank;
    assign cap_evt   = evt_q && anode_ok && good;
    assign seg_evt   = evt_q && anode_ok && !good;
    assign anode_evt = evt_q && !anode_ok && !anode_idle;
    assign stalled   = cap_valid && !cap_ready;
    assign mask_full = &mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid  <= 1'b0;
            cap_idx    <= '0;
            cap_nib    <= '0;
            cap_blank  <= 1'b0;
            digits     <= '0;
            mask       <= '0;
            frame_done <= 1'b0;
            seg_err    <= 1'b0;
            anode_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= mask_full;
            mask       <= (mask_full ? 8'h00 : mask) | (cap_evt ? (8'd1 << dec_idx) : 8'h00);

            if (cap_evt && dec.hit) digits[{dec_idx, 2'b00} +: 4] <= dec.nib;

            // A capture arriving while the consumer stalls is dropped; the held one stays intact.
            if (cap_evt && !stalled) begin
                cap_valid <= 1'b1;
                cap_idx   <= dec_idx;
                cap_nib   <= dec.nib;
                cap_blank <= dec.blank;
            end else if (cap_ready) begin
                cap_valid <= 1'b0;
            end

            // A new error in the same cycle as err_clr keeps its flag set.
            seg_err   <= seg_evt                | (seg_err   && !err_clr);
            anode_err <= anode_evt              | (anode_err && !err_clr);
            overflow  <= (cap_evt && stalled)   | (overflow  && !err_clr);
        end
    end

endmodule
